// File: rtl/s2_pkg.sv
// Shared constants, state encoding and helpers for the sen/sd serial receiver.
package s2_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 18;
  localparam int unsigned FRAME_W  = ADDR_W + DATA_W;
  localparam int unsigned NUM_ADDR = 8;
  localparam int unsigned CNT_W    = $clog2(FRAME_W + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [NUM_ADDR-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_ADDR-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/s2_deser.sv
// FRAME_W-bit MSB-first shift register with bit counter and frame flags.
module s2_deser
  import s2_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               shift_i,
  input  logic               abort_i,
  input  logic               sd_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               complete_o,
  output logic               short_o
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Frame contents including the bit being sampled at this edge.
  assign frame_o    = {shift_q[FRAME_W-2:0], sd_i};
  assign complete_o = shift_i && (cnt_q == CNT_W'(FRAME_W - 1));
  assign short_o    = abort_i && (cnt_q < CNT_W'(FRAME_W));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      shift_d = {{(FRAME_W-1){1'b0}}, sd_i};
      cnt_d   = CNT_W'(1);
    end else if (shift_i) begin
      shift_d = frame_o;
      cnt_d   = complete_o ? '0 : cnt_q + CNT_W'(1);
    end else if (abort_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/s2_receiver.sv
// Receives 21-bit sen/sd frames, writes them into RB2 and flags a complete address round.
module s2_receiver
  import s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              done,
  output logic              frame_err
);

  logic [1:0]          state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_ADDR-1:0] mask_q, mask_d, mask_next;

  logic               start, shift, abort;
  logic [FRAME_W-1:0] frame;
  logic               complete, short_frame;

  assign start = (state_q == StIdle) && !sen;
  assign shift = (state_q == StShift) && !sen;
  assign abort = (state_q == StShift) && sen;

  s2_deser u_deser (
    .clk_i      (clk),
    .rst_ni     (rst),
    .start_i    (start),
    .shift_i    (shift),
    .abort_i    (abort),
    .sd_i       (sd),
    .frame_o    (frame),
    .complete_o (complete),
    .short_o    (short_frame)
  );

  always_comb begin
    state_d   = state_q;
    rw_d      = RW_READ;
    a_d       = a_q;
    d_d       = d_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mask_d    = mask_q;
    mask_next = mask_q | addr_onehot(a_q);
    case (state_q)
      StIdle: begin
        if (!sen) state_d = StShift;
      end
      StShift: begin
        if (sen) begin
          err_d   = short_frame;
          state_d = StIdle;
        end else if (complete) begin
          a_d     = frame[FRAME_W-1 -: ADDR_W];
          d_d     = frame[DATA_W-1:0];
          rw_d    = RW_WRITE;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The round completes on the edge that ends its last write; mask restarts at once.
        if (mask_next == '1) begin
          done_d = 1'b1;
          mask_d = '0;
        end else begin
          mask_d = mask_next;
        end
        if (sen) begin
          state_d = StIdle;
        end else begin
          err_d   = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (sen) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rw_q    <= RW_READ;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      a_q     <= a_d;
      d_q     <= d_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign RB2_RW    = rw_q;
  assign RB2_A     = a_q;
  assign RB2_D     = d_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: doc/s2_receiver.md
Name: s2_receiver

Overview:
- Serial receiver at the far end of the sen/sd link.
- Deserialises frames of 21 bits: a 3-bit RB2 address followed by 18 data bits.
- Writes each completed frame into register bank RB2 with a one-cycle write strobe.
- Pulses done once all 8 RB2 addresses have been written.

Parameters:
ADDR_W, 3, RB2 address width / frame header bits
DATA_W, 18, RB2 data width / frame payload bits
FRAME_W, 21, total bits per frame (ADDR_W+DATA_W)
NUM_ADDR, 8, distinct addresses required before done

Ports:
clk  input  1  system clock; all sampling on rising edge
rst  input  1  asynchronous, active-low reset
sen  input  1  serial enable, active low; low for exactly FRAME_W cycles per frame
sd  input  1  serial data; transmitter changes it on the falling edge, sampled here on the rising edge while sen==0
RB2_RW  output  1  RB2 control: 1=read/idle, 0=write
RB2_A  output  ADDR_W  RB2 address
RB2_D  output  DATA_W  RB2 write data
done  output  1  one-cycle pulse after all NUM_ADDR addresses are written
frame_err  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, bit_cnt=0, shift register=0, written mask=0, RB2_RW=1, RB2_A=0, RB2_D=0, done=0, frame_err=0. Reset mid-frame discards the partial frame; no write occurs.
- Bit order: MSB first. Bits 1..3 form A[2:0]; bits 4..21 form D[17:0].
- FSM states: IDLE, SHIFT, WRITE, DRAIN. All outputs are registered.
- IDLE: sen==0 at an edge -> shift in sd, bit_cnt=1, go to SHIFT. sen==1 -> stay.
- SHIFT: sen==0 -> shift in sd, bit_cnt+1.
  - At the edge capturing bit 21: RB2_A<=shift[20:18], RB2_D<=shift[17:0] (including the new bit), RB2_RW<=0, go to WRITE.
  - sen==1 with bit_cnt<21 (short frame) -> frame_err<=1 for one cycle, no write, bit_cnt=0, go to IDLE.
- WRITE: lasts one cycle. RB2_RW=0 is visible for exactly one clk period, with A/D stable. Next edge: RB2_RW<=1; A/D hold their values until the next write.
  - Set written_mask[RB2_A].
  - sen==1 at this edge -> IDLE.
  - sen==0 at this edge (long frame, i.e. 22nd bit) -> the write already issued stands, frame_err pulses, go to DRAIN.
- DRAIN: ignore sd until sen==1, then go to IDLE. No writes while in DRAIN.
- Minimum inter-frame gap is 1 cycle with sen high. A back-to-back frame starting the cycle after the WRITE-edge sen==1 sample is accepted.
- Write-to-write latency is 22 cycles at the minimum gap.
- Latency: RB2_RW falls on the edge that samples bit 21, i.e. 0 cycles after the last bit.
- done:
  - Fires on the edge after the write that makes written_mask all ones.
  - A duplicate address does not advance the mask.
  - After done fires, the mask clears to 0 in the same cycle, and reception continues so a new 8-address round can begin.
- Simultaneous events: the final mask-completing write and a new frame's first bit may coincide. Both are handled; done is unaffected by the new frame.

Decomposition:
- Shared package s2_pkg holds:
  - the state encoding (IDLE=0, SHIFT=1, WRITE=2, DRAIN=3);
  - ADDR_W, DATA_W, FRAME_W, NUM_ADDR constants;
  - RB2_RW encodings (RW_READ=1, RW_WRITE=0).
- One natural sub-module: s2_deser, a FRAME_W-bit shift register with bit counter and frame-complete/short-frame flags. The FSM, RB2 interface and done logic stay in s2_receiver.

Test Plan:
- Reset release, sen held high for 10 cycles -> RB2_RW=1, RB2_A=0, RB2_D=0, done=0, frame_err=0 throughout.
- Single frame with addr=3'b101, data=18'h2A5C3 -> exactly one cycle of RB2_RW=0 with RB2_A=5, RB2_D=18'h2A5C3, aligned to the bit-21 edge; no frame_err.
- 8 back-to-back frames, addresses 0..7, 1-cycle gaps, data=18'h00001<<addr -> 8 writes with the correct A/D; done pulses once, 1 cycle after the 8th write.
- Frame cut after 12 bits (sen rises) -> frame_err pulse; no write. A following valid frame addr=2, data=18'h3FFFF is written correctly.
- sen held low for 25 bits -> write of the first 21 bits occurs, frame_err pulses, and there are no further writes until sen goes high. The next frame is received normally.
- rst asserted low at bit 10 of a frame, released, then a full frame addr=7, data=18'h12345 is sent -> no write for the aborted frame; one write A=7, D=18'h12345; written_mask contains only bit 7.
